// File: rtl/mult_arb_pkg.sv
// Shared constants and helpers for the multiplier arbiter slice.
package mult_arb_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_R = 4;

  function automatic int calc_idw(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  // Pointer value after reset: makes requester 0 the first candidate.
  function automatic int rst_last(input int r);
    return r - 1;
  endfunction

endpackage

// File: rtl/n_bit_multiplier.sv
// Combinational full-width unsigned multiplier.
// Zero latency; no flow control.
module n_bit_multiplier #(
  parameter int N = 32
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  logic [2*N-1:0] w_a_ext;
  logic [2*N-1:0] w_b_ext;

  assign w_a_ext = {{N{1'b0}}, i_a};
  assign w_b_ext = {{N{1'b0}}, i_b};
  assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// Combinational grant; pointer advances only when the grant is accepted.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int R   = DEF_R,
  parameter int IDW = calc_idw(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic           accept,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] r_last;
  logic           w_found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= R; k++) begin
      if (!w_found && req[(int'(r_last) + k) % R]) begin
        w_found                          = 1'b1;
        grant[(int'(r_last) + k) % R]    = 1'b1;
        grant_id                         = IDW'((int'(r_last) + k) % R);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDW'(rst_last(R));
    end else if (accept) begin
      r_last <= grant_id;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier among R requesters, round-robin, tagged registered response.
// Latency 1 (2 with MULT_IN_REG_EN); rsp held while ~rsp_ready, which stalls grants.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int R   = DEF_R,
  parameter int IDW = calc_idw(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  output logic [R-1:0]     req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [2*N-1:0]   rsp_product
);

  logic [R-1:0]   w_grant;
  logic [IDW-1:0] w_gid;
  logic           w_adv_out;
  logic           w_adv_in;
  logic           w_accept;
  logic [N-1:0]   w_mux_a;
  logic [N-1:0]   w_mux_b;
  logic           w_mul_vld;
  logic [IDW-1:0] w_mul_id;
  logic [N-1:0]   w_mul_a;
  logic [N-1:0]   w_mul_b;
  logic [2*N-1:0] w_prod;

  logic           r_rsp_vld;
  logic [IDW-1:0] r_rsp_id;
  logic [2*N-1:0] r_rsp_prod;

  assign w_adv_out = ~r_rsp_vld | rsp_ready;
  assign req_ready = w_grant & {R{w_adv_in & ~rst}};
  assign w_accept  = |req_ready;

  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .accept   (w_accept),
    .grant    (w_grant),
    .grant_id (w_gid)
  );

  // One-hot AND-OR operand select.
  always_comb begin
    w_mux_a = '0;
    w_mux_b = '0;
    for (int i = 0; i < R; i++) begin
      if (w_grant[i]) begin
        w_mux_a = w_mux_a | req_a[i*N +: N];
        w_mux_b = w_mux_b | req_b[i*N +: N];
      end
    end
  end

`ifdef MULT_IN_REG_EN
  logic           r_s1_vld;
  logic [IDW-1:0] r_s1_id;
  logic [N-1:0]   r_s1_a;
  logic [N-1:0]   r_s1_b;

  assign w_adv_in = ~r_s1_vld | w_adv_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
    end else if (w_adv_in) begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_id <= w_gid;
        r_s1_a  <= w_mux_a;
        r_s1_b  <= w_mux_b;
      end
    end
  end

  assign w_mul_vld = r_s1_vld;
  assign w_mul_id  = r_s1_id;
  assign w_mul_a   = r_s1_a;
  assign w_mul_b   = r_s1_b;
`else
  assign w_adv_in  = w_adv_out;
  assign w_mul_vld = w_accept;
  assign w_mul_id  = w_gid;
  assign w_mul_a   = w_mux_a;
  assign w_mul_b   = w_mux_b;
`endif

  n_bit_multiplier #(.N(N)) u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_prod <= '0;
    end else if (w_adv_out) begin
      r_rsp_vld <= w_mul_vld;
      if (w_mul_vld) begin
        r_rsp_id   <= w_mul_id;
        r_rsp_prod <= w_prod;
      end
    end
  end

  assign rsp_valid   = r_rsp_vld;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_prod;

endmodule
